// File: rtl/mdu_div_pkg.sv
// mdu_div_pkg: shared constants and types for the iterative divider.
//   div_state_e        : divider FSM state encoding
//   DIV_DATA_W_DEFAULT : default operand width
package mdu_div_pkg;

  localparam int DIV_DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;

endpackage

// File: rtl/mdu_div_clz.sv
// mdu_clz: combinational leading-zero counter.
//   a_i  [DATA_W-1:0]          : value to scan
//   lz_o [$clog2(DATA_W):0]    : number of leading zeros (DATA_W when a_i == 0)
module mdu_clz #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]        a_i,
  output logic [$clog2(DATA_W):0]  lz_o
);

  localparam int LZ_W = $clog2(DATA_W) + 1;

  // Ascending scan: the highest set bit is the last one to write lz_o.
  always_comb begin
    lz_o = LZ_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (a_i[i]) lz_o = LZ_W'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/mdu_div.sv
// mdu_div: parametrised restoring divider (one quotient bit per clock).
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : request, held by EX until the result is consumed
//   annul_i           : abort (pipeline flush)
//   signed_div_i      : 1 = two's-complement operands
//   opdata1_i/2_i     : dividend / divisor
//   result_o          : {remainder, quotient}, valid while ready_o
//   ready_o           : result valid
//   busy_o            : division in progress (ZERO or ON)
// Optional build macro MDU_DIV_EARLY_OUT_EN: skip the dividend's leading
// zeros so latency becomes DATA_W - clz(|dividend|) edges.
module mdu_div
  import mdu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e              state_q;
  logic [DATA_W-1:0]       dvd_q;     // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]       dvs_q;     // divisor magnitude
  logic [DATA_W-1:0]       rem_q;     // partial remainder
  logic [CNT_W-1:0]        cnt_q;
  logic                    neg_quo_q, neg_rem_q;
  logic [2*DATA_W-1:0]     result_q;
  logic                    ready_q;

  // Operand magnitudes (unsigned mode passes operands through untouched)
  logic [DATA_W-1:0] dvd_abs, dvs_abs;
  logic              dvd_neg, dvs_neg;

  assign dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign dvd_abs = dvd_neg ? -opdata1_i : opdata1_i;
  assign dvs_abs = dvs_neg ? -opdata2_i : opdata2_i;

  // One restoring step. The partial remainder is always below the divisor,
  // so the trial fits in DATA_W+2 bits and a non-negative trial is < 2^DATA_W.
  logic [DATA_W+1:0] trial;
  logic              qbit;
  logic [DATA_W-1:0] rem_d, quo_d, quo_fix, rem_fix;

  always_comb begin
    trial   = {1'b0, rem_q, dvd_q[DATA_W-1]} - {2'b00, dvs_q};
    qbit    = (trial[DATA_W+1:DATA_W] == 2'b00);
    rem_d   = qbit ? trial[DATA_W-1:0] : {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
    quo_d   = {dvd_q[DATA_W-2:0], qbit};
    quo_fix = neg_quo_q ? -quo_d : quo_d;
    rem_fix = neg_rem_q ? -rem_d : rem_d;
  end

`ifdef MDU_DIV_EARLY_OUT_EN
  logic [CNT_W:0] lz;
  logic           dvd_zero;

  mdu_clz #(.DATA_W(DATA_W)) u_clz (
    .a_i  (dvd_abs),
    .lz_o (lz)
  );

  assign dvd_zero = (lz == (CNT_W+1)'(DATA_W));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start_i && !annul_i) begin
            dvs_q     <= dvs_abs;
            rem_q     <= '0;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
`ifdef MDU_DIV_EARLY_OUT_EN
            // Leading zeros of the dividend only produce zero quotient bits,
            // so they are shifted out up front and counted as done.
            dvd_q <= dvd_abs << lz;
            cnt_q <= lz[CNT_W-1:0];
            if (dvs_abs == '0 || dvd_zero) state_q <= DIV_ZERO;
            else                           state_q <= DIV_ON;
`else
            dvd_q <= dvd_abs;
            cnt_q <= '0;
            if (dvs_abs == '0) state_q <= DIV_ZERO;
            else               state_q <= DIV_ON;
`endif
          end
        end

        DIV_ZERO: begin
          if (annul_i) begin
            state_q <= DIV_IDLE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= DIV_END;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            state_q <= DIV_IDLE;
          end else begin
            dvd_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              result_q <= {rem_fix, quo_fix};
              ready_q  <= 1'b1;
              state_q  <= DIV_END;
            end
          end
        end

        DIV_END: begin
          // Result stays put while EX holds start_i.
          if (annul_i || !start_i) begin
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= DIV_IDLE;
          end
        end

        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DIV_ON) || (state_q == DIV_ZERO);

endmodule

// File: tb/tb_mdu_div.sv
module tb_mdu_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];
  logic        rdy_prev = 1'b0;

  mdu_div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: every rising ready_o pops one expected result.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && ready_o && !rdy_prev) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready act=%h exp=none", result_o);
      end else begin
        e = sb_q.pop_front();
        chk("sb_result", result_o, e);
      end
    end
    rdy_prev = ready_o;
  end

  // Issue one division, hold start 5 cycles past ready, then release.
  task automatic run_div(input string nm, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input int exp_busy);
    int bc = 0;
    int n  = 0;
    sb_q.push_back({er, eq});
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    do begin
      @(negedge clk);
      if (busy_o) bc++;
      n++;
    end while (!ready_o && n < 100);
    chk({nm, "_ready"}, 64'(ready_o), 64'd1);
    if (exp_busy >= 0) chk({nm, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    repeat (5) begin
      @(negedge clk);
      chk({nm, "_hold_ready"}, 64'(ready_o), 64'd1);
      chk({nm, "_hold_result"}, result_o, {er, eq});
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({nm, "_drop_ready"}, 64'(ready_o), 64'd0);
    chk({nm, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int lat_100_7;
`ifdef MDU_DIV_EARLY_OUT_EN
    lat_100_7 = 7;
`else
    lat_100_7 = 32;
`endif
    repeat (3) @(negedge clk);
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("u100_7",   1'b0, 32'd100,       32'd7,        32'h0000000E, 32'h00000002, lat_100_7);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, -1);
    run_div("s_7_m2",   1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, -1);
    run_div("s_m8_m3",  1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFE, -1);
    run_div("s_minint", 1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'h00000000, -1);
    run_div("u_minint", 1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, -1);
    run_div("div_zero", 1'b0, 32'h12345678,  32'd0,        32'h00000000, 32'h00000000, 1);
    run_div("u_0_5",    1'b0, 32'd0,         32'd5,        32'h00000000, 32'h00000000, -1);

    // start and annul together in IDLE: no start
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("start_annul_busy", 64'(busy_o), 64'd0);
    end
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);

    // annul mid-iteration: ready never rises (monitor flags any rise)
    opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("annul_pre_busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    chk("annul_busy", 64'(busy_o), 64'd0);
    chk("annul_ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("annul_no_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, 64'd0);

    run_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, -1);

    // reset in the middle of ON
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("midon_busy_pre", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midon_rst_busy", 64'(busy_o), 64'd0);
    chk("midon_rst_ready", 64'(ready_o), 64'd0);
    chk("midon_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
